modport_bridge: RTL and testbench
=================================

Name: modport_bridge

Overview:
- Registered pass-through stage between an upstream AXI-stream sink and a downstream AXI-stream source, with a 2-entry skid buffer.
- Framing checker marks protocol violations in the beat's err bit.
- Statistics counters are readable over a simple memory-mapped port.
- Sits between packet producers and consumers as a link monitor and timing break.

Parameters:
- DAT_BYTS, 8, stream data width in bytes
- DAT_BITS, DAT_BYTS*8, stream data width in bits
- CTL_BITS, 8, sideband control width
- MOD_BITS, (DAT_BYTS==1 ? 1 : clog2(DAT_BYTS)), byte-count width on the last beat
- MM_D_BITS, 64, register read/write data width
- MM_A_BITS, 8, register address width

Ports:
- i_clk, in, 1, single clock
- i_rst_n, in, 1, asynchronous active-low reset
- i_val / i_sop / i_eop / i_err, in, 1 each, sink beat valid / packet start / packet end / upstream error
- i_ctl, in, CTL_BITS, sink sideband control
- i_dat, in, DAT_BITS, sink data
- i_mod, in, MOD_BITS, sink valid-byte count on the last beat
- o_rdy, out, 1, sink ready
- o_val / o_sop / o_eop / o_err / o_ctl / o_dat / o_mod, out, as the matching sink signals, source beat
- i_rdy, in, 1, source ready from downstream
- i_mm_addr, in, MM_A_BITS, register address
- i_mm_wr / i_mm_rd, in, 1 each, write strobe / read strobe
- i_mm_wr_dat, in, MM_D_BITS, write data
- o_mm_rd_dat, out, MM_D_BITS, read data
- o_mm_rd_dat_val, out, 1, read data valid
- o_mm_wait_rq, out, 1, wait request

Behaviour:
- Reset (async assert, sync release): all outputs 0, counters 0, skid buffer empty, framing state IDLE.
- o_rdy is 1 after reset release.
- A beat transfers on the sink when i_val && o_rdy, and on the source when o_val && i_rdy.
- Skid buffer:
  - 2 entries; o_rdy is registered and equals "fewer than 2 entries held, or 1 held and draining this cycle".
  - Latency is 1 cycle from sink acceptance to o_val.
  - Sustains 1 beat/cycle with i_rdy held high.
  - No beat is ever lost or duplicated under any i_rdy pattern.
- Source outputs are held stable while o_val && !i_rdy.
- Framing FSM, updated on every sink acceptance:
  - IDLE, beat with sop: forward unchanged; go to IN_PKT unless eop is also set.
  - IDLE, beat without sop: forward with err=1 and sop=1 (the beat opens a packet); count a framing error.
  - IN_PKT, beat with sop: forward with err=1 (the previous packet is truncated); count a framing error; the beat starts a new packet.
  - Any state, beat with eop: next state is IDLE.
  - i_err=1 on an accepted beat propagates to o_err and counts as an error, at most 1 per beat.
- mod: passed through unchanged. For byte counting, a beat counts DAT_BYTS bytes if !eop or mod==0, otherwise mod bytes.
- Counters: 32 bits, wrap modulo 2^32, updated on source transfers.
  - PKT: +1 per beat with eop.
  - BEAT: +1 per beat.
  - BYTE: + byte count of the beat.
  - ERR: +1 per beat with o_err.
- Register map (word addresses):
  - 0x00 PKT, 0x01 BEAT, 0x02 BYTE, 0x03 ERR, all read-only; writes ignored.
  - 0x04 CTRL: writing bit0=1 clears all counters (self-clearing); reads 0.
  - Unmapped addresses read 0.
  - Counters are zero-extended to MM_D_BITS.
- MM timing:
  - o_mm_wait_rq is always 0.
  - A read (i_mm_rd) gives o_mm_rd_dat_val=1 for exactly one cycle, the next cycle, with data sampled on the strobe cycle.
  - o_mm_rd_dat holds its last value otherwise.
  - Simultaneous rd and wr to CTRL: the read returns 0 and the clear takes effect.
- Clear vs increment in the same cycle: clear wins and the counter is 0 afterwards.
- Reset asserted mid-packet: discard buffered beats, return to IDLE, zero counters.

Test Plan:
- 3-beat packet with DAT_BYTS=8: beats (sop), (), (eop, mod=5), i_rdy=1 → identical beats on the source 1 cycle later, err=0; PKT=1, BEAT=3, BYTE=21, ERR=0.
- Random i_rdy at 50% for 100 single-beat packets with incrementing dat → all 100 delivered in order with no drops; o_rdy never 1 while 2 entries are held and not draining.
- Beat without sop while IDLE → output sop=1, err=1; ERR=1. Then sop arrives mid-packet → that beat has err=1; ERR=2.
- Beat with i_err=1 and eop, mod=0 → o_err=1; ERR+1; BYTE+8.
- MM: read 0x01 after 4 beats → rd_dat_val one cycle later, data 4. Write 0x04=1 in the same cycle as a counted beat → all counters 0. Read 0x7F → 0.
- Assert i_rst_n=0 with 2 beats buffered → o_val=0 immediately, counters 0; after release o_rdy=1 and a new packet passes cleanly.

Source files
------------

// File: rtl/modport_bridge_if.sv
// Interfaces used by modport_bridge.
//
// modport_bridge_stream_if : one AXI-stream style beat channel.
//   val  - beat valid (driven by master)
//   rdy  - beat ready (driven by slave)
//   sop  - packet start
//   eop  - packet end
//   err  - error flag carried with the beat
//   ctl  - sideband control, CTL_BITS wide
//   dat  - beat data, DAT_BITS wide
//   mod  - valid-byte count on the last beat (0 means all bytes)
//
// modport_bridge_mm_if : simple memory-mapped register port.
//   addr       - word address (master)
//   wr / rd    - write / read strobes (master)
//   wr_dat     - write data (master)
//   rd_dat     - read data (slave)
//   rd_dat_val - read data valid, one cycle after the read strobe (slave)
//   wait_rq    - wait request, tied low by the slave (slave)

interface modport_bridge_stream_if #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8,
  parameter int DAT_BITS = DAT_BYTS * 8,
  parameter int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS)
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [CTL_BITS-1:0] ctl;
  logic [DAT_BITS-1:0] dat;
  logic [MOD_BITS-1:0] mod;

  modport master (
    output val, sop, eop, err, ctl, dat, mod,
    input  rdy
  );

  modport slave (
    input  val, sop, eop, err, ctl, dat, mod,
    output rdy
  );
endinterface

interface modport_bridge_mm_if #(
  parameter int MM_A_BITS = 8,
  parameter int MM_D_BITS = 64
);
  logic [MM_A_BITS-1:0] addr;
  logic                 wr;
  logic                 rd;
  logic [MM_D_BITS-1:0] wr_dat;
  logic [MM_D_BITS-1:0] rd_dat;
  logic                 rd_dat_val;
  logic                 wait_rq;

  modport master (
    output addr, wr, rd, wr_dat,
    input  rd_dat, rd_dat_val, wait_rq
  );

  modport slave (
    input  addr, wr, rd, wr_dat,
    output rd_dat, rd_dat_val, wait_rq
  );
endinterface

// File: rtl/modport_bridge.sv
// modport_bridge: registered stream pass-through with a 2-entry skid
// buffer, a framing checker and memory-mapped statistics counters.
//
// Ports:
//   i_clk   - single clock
//   i_rst_n - asynchronous active-low reset, released synchronously upstream
//   snk     - upstream beat channel (this block is the slave)
//   src     - downstream beat channel (this block is the master)
//   mm      - register port: 0x00 PKT, 0x01 BEAT, 0x02 BYTE, 0x03 ERR
//             (read-only), 0x04 CTRL (write bit0=1 clears counters)

module modport_bridge #(
  parameter int DAT_BYTS  = 8,
  parameter int DAT_BITS  = DAT_BYTS * 8,
  parameter int CTL_BITS  = 8,
  parameter int MOD_BITS  = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS),
  parameter int MM_D_BITS = 64,
  parameter int MM_A_BITS = 8
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  modport_bridge_stream_if.slave   snk,
  modport_bridge_stream_if.master  src,
  modport_bridge_mm_if.slave       mm
);

  localparam logic [MM_A_BITS-1:0] ADDR_PKT  = MM_A_BITS'(0);
  localparam logic [MM_A_BITS-1:0] ADDR_BEAT = MM_A_BITS'(1);
  localparam logic [MM_A_BITS-1:0] ADDR_BYTE = MM_A_BITS'(2);
  localparam logic [MM_A_BITS-1:0] ADDR_ERR  = MM_A_BITS'(3);
  localparam logic [MM_A_BITS-1:0] ADDR_CTRL = MM_A_BITS'(4);

  typedef struct packed {
    logic                sop;
    logic                eop;
    logic                err;
    logic [CTL_BITS-1:0] ctl;
    logic [DAT_BITS-1:0] dat;
    logic [MOD_BITS-1:0] mod;
  } beat_t;

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } frm_state_t;

  frm_state_t frm_state;

  beat_t in_beat;
  beat_t out_q;
  beat_t skid_q;
  logic  out_val_q;
  logic  skid_val_q;
  logic  rdy_q;

  logic  accept;
  logic  drain;
  logic  load_out;
  logic  out_val_n;
  logic  skid_val_n;

  logic [31:0] pkt_cnt;
  logic [31:0] beat_cnt;
  logic [31:0] byte_cnt;
  logic [31:0] err_cnt;
  logic [31:0] beat_bytes;
  logic        clear;

  logic [MM_D_BITS-1:0] rd_mux;
  logic [MM_D_BITS-1:0] rd_dat_q;
  logic                 rd_dat_val_q;

  logic unused_wr_bits;

  assign accept   = snk.val && rdy_q;
  assign drain    = out_val_q && src.rdy;
  // The output register can take a new beat when it is empty or emptying.
  assign load_out = !out_val_q || drain;

  // Framing fix-ups applied to the incoming beat: a stray beat in IDLE is
  // promoted to a packet start, a sop inside a packet flags truncation.
  always_comb begin
    in_beat.sop = snk.sop;
    in_beat.eop = snk.eop;
    in_beat.err = snk.err;
    in_beat.ctl = snk.ctl;
    in_beat.dat = snk.dat;
    in_beat.mod = snk.mod;
    if (frm_state == ST_IDLE && !snk.sop) begin
      in_beat.sop = 1'b1;
      in_beat.err = 1'b1;
    end
    if (frm_state == ST_IN_PKT && snk.sop) begin
      in_beat.err = 1'b1;
    end
  end

  // Occupancy after this edge; the skid entry only fills while the output
  // register is stalled, and empties into the output register first.
  always_comb begin
    if (load_out) begin
      out_val_n  = skid_val_q || accept;
      skid_val_n = skid_val_q && accept;
    end else begin
      out_val_n  = 1'b1;
      skid_val_n = skid_val_q || accept;
    end
  end

  // Framing state advances on every accepted beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frm_state <= ST_IDLE;
    end else if (accept) begin
      frm_state <= snk.eop ? ST_IDLE : ST_IN_PKT;
    end
  end

  // Skid buffer storage; ready is registered from next-cycle occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_val_q  <= 1'b0;
      skid_val_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_val_q  <= out_val_n;
      skid_val_q <= skid_val_n;
      rdy_q      <= !(out_val_n && skid_val_n);
      if (load_out) begin
        if (skid_val_q) begin
          out_q <= skid_q;
        end else if (accept) begin
          out_q <= in_beat;
        end
      end
      if (accept && (skid_val_q || !load_out)) begin
        skid_q <= in_beat;
      end
    end
  end

  assign snk.rdy = rdy_q;
  assign src.val = out_val_q;
  assign src.sop = out_q.sop;
  assign src.eop = out_q.eop;
  assign src.err = out_q.err;
  assign src.ctl = out_q.ctl;
  assign src.dat = out_q.dat;
  assign src.mod = out_q.mod;

  // A full beat is counted unless it is the last one with a partial count.
  assign beat_bytes = (!out_q.eop || out_q.mod == '0) ? 32'(DAT_BYTS)
                                                      : 32'(out_q.mod);

  assign clear = mm.wr && (mm.addr == ADDR_CTRL) && mm.wr_dat[0];

  // Statistics on source transfers; a clear overrides any increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
      byte_cnt <= '0;
      err_cnt  <= '0;
    end else if (clear) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
      byte_cnt <= '0;
      err_cnt  <= '0;
    end else if (drain) begin
      pkt_cnt  <= pkt_cnt + 32'(out_q.eop);
      beat_cnt <= beat_cnt + 32'd1;
      byte_cnt <= byte_cnt + beat_bytes;
      err_cnt  <= err_cnt + 32'(out_q.err);
    end
  end

  // Register read mux; CTRL and unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (mm.addr)
      ADDR_PKT:  rd_mux = MM_D_BITS'(pkt_cnt);
      ADDR_BEAT: rd_mux = MM_D_BITS'(beat_cnt);
      ADDR_BYTE: rd_mux = MM_D_BITS'(byte_cnt);
      ADDR_ERR:  rd_mux = MM_D_BITS'(err_cnt);
      default:   rd_mux = '0;
    endcase
  end

  // Read data is captured on the strobe and held until the next read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_dat_q     <= '0;
      rd_dat_val_q <= 1'b0;
    end else begin
      rd_dat_val_q <= mm.rd;
      if (mm.rd) begin
        rd_dat_q <= rd_mux;
      end
    end
  end

  assign mm.rd_dat     = rd_dat_q;
  assign mm.rd_dat_val = rd_dat_val_q;
  assign mm.wait_rq    = 1'b0;

  assign unused_wr_bits = ^mm.wr_dat[MM_D_BITS-1:1];

endmodule

// File: tb/tb_modport_bridge.sv
// Testbench for modport_bridge: directed packets plus randomized traffic,
// checked by a scoreboard fed from a behavioural model of the framing and
// counter rules.

module tb_modport_bridge;

  localparam int DAT_BYTS  = 8;
  localparam int CTL_BITS  = 8;
  localparam int DAT_BITS  = DAT_BYTS * 8;
  localparam int MOD_BITS  = 3;
  localparam int MM_A_BITS = 8;
  localparam int MM_D_BITS = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  modport_bridge_stream_if #(.DAT_BYTS(DAT_BYTS), .CTL_BITS(CTL_BITS)) snk_if ();
  modport_bridge_stream_if #(.DAT_BYTS(DAT_BYTS), .CTL_BITS(CTL_BITS)) src_if ();
  modport_bridge_mm_if #(.MM_A_BITS(MM_A_BITS), .MM_D_BITS(MM_D_BITS)) mm_if ();

  modport_bridge #(
    .DAT_BYTS (DAT_BYTS),
    .CTL_BITS (CTL_BITS),
    .MM_D_BITS(MM_D_BITS),
    .MM_A_BITS(MM_A_BITS)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .snk    (snk_if),
    .src    (src_if),
    .mm     (mm_if)
  );

  typedef struct {
    logic                sop;
    logic                eop;
    logic                err;
    logic [CTL_BITS-1:0] ctl;
    logic [DAT_BITS-1:0] dat;
    logic [MOD_BITS-1:0] mod;
    int                  cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] rd_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pkt, m_beat, m_byte, m_err;
  bit          m_in_pkt;
  int          delivered;
  int          cyc;
  bit          lat_check;
  bit          rand_rdy;
  bit          prev_rd;
  bit          prev_stall;
  logic [77:0] prev_vec;

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [77:0] src_vec();
    return {src_if.sop, src_if.eop, src_if.err, src_if.ctl, src_if.dat, src_if.mod};
  endfunction

  function automatic logic [31:0] model_bytes(input logic eop, input logic [MOD_BITS-1:0] mod);
    if (!eop || mod == 0) return 32'(DAT_BYTS);
    return 32'(mod);
  endfunction

  function automatic logic [63:0] model_read(input logic [MM_A_BITS-1:0] addr);
    case (addr)
      8'h00:   return 64'(m_pkt);
      8'h01:   return 64'(m_beat);
      8'h02:   return 64'(m_byte);
      8'h03:   return 64'(m_err);
      default: return 64'd0;
    endcase
  endfunction

  // Monitor / scoreboard: samples once per cycle, well after the edge.
  initial begin
    m_pkt = 0; m_beat = 0; m_byte = 0; m_err = 0;
    m_in_pkt = 0; delivered = 0; cyc = 0; prev_rd = 0; prev_stall = 0;
    prev_vec = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        rd_q.delete();
        m_pkt = 0; m_beat = 0; m_byte = 0; m_err = 0;
        m_in_pkt = 0;
        prev_rd = 0;
        prev_stall = 0;
      end else begin
        check_output("rd_dat_val", mm_if.rd_dat_val, prev_rd);
        if (mm_if.rd_dat_val && rd_q.size() > 0)
          check_output("rd_dat", mm_if.rd_dat, rd_q.pop_front());
        check_output("wait_rq", mm_if.wait_rq, 0);
        if (mm_if.rd) rd_q.push_back(model_read(mm_if.addr));

        if (prev_stall) check_output("src_hold", src_vec(), prev_vec);
        if (exp_q.size() >= 2) check_output("rdy_when_full", snk_if.rdy, 0);

        if (src_if.val && exp_q.size() == 0) check_output("src_unexpected", src_if.val, 0);
        if (src_if.val && src_if.rdy && exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("src_beat", src_vec(), {e.sop, e.eop, e.err, e.ctl, e.dat, e.mod});
          if (lat_check) check_output("latency", cyc - e.cyc, 1);
          m_beat = m_beat + 1;
          if (e.eop) m_pkt = m_pkt + 1;
          if (e.err) m_err = m_err + 1;
          m_byte = m_byte + model_bytes(e.eop, e.mod);
          delivered++;
        end

        if (snk_if.val && snk_if.rdy) begin
          exp_t e;
          e.sop = snk_if.sop;
          e.eop = snk_if.eop;
          e.err = snk_if.err;
          e.ctl = snk_if.ctl;
          e.dat = snk_if.dat;
          e.mod = snk_if.mod;
          e.cyc = cyc;
          if (!m_in_pkt && !snk_if.sop) begin
            e.sop = 1;
            e.err = 1;
          end
          if (m_in_pkt && snk_if.sop) e.err = 1;
          m_in_pkt = !snk_if.eop;
          exp_q.push_back(e);
        end

        if (mm_if.wr && mm_if.addr == 8'h04 && mm_if.wr_dat[0]) begin
          m_pkt = 0; m_beat = 0; m_byte = 0; m_err = 0;
        end

        prev_rd    = mm_if.rd;
        prev_stall = src_if.val && !src_if.rdy;
        prev_vec   = src_vec();
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) src_if.rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic sop, input logic eop, input logic err,
                                input logic [MOD_BITS-1:0] mod, input logic [DAT_BITS-1:0] dat);
    int n;
    @(negedge clk);
    snk_if.val = 1;
    snk_if.sop = sop;
    snk_if.eop = eop;
    snk_if.err = err;
    snk_if.mod = mod;
    snk_if.dat = dat;
    snk_if.ctl = 8'($urandom);
    #1;
    n = 0;
    while (!snk_if.rdy && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 500) check_output("sink_timeout", snk_if.rdy, 1);
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    snk_if.val = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic mm_read(input logic [MM_A_BITS-1:0] addr, output logic [63:0] data);
    @(negedge clk);
    mm_if.addr = addr;
    mm_if.rd   = 1;
    @(negedge clk);
    mm_if.rd = 0;
    #1;
    data = mm_if.rd_dat;
  endtask

  task automatic mm_write(input logic [MM_A_BITS-1:0] addr, input logic [63:0] data);
    @(negedge clk);
    mm_if.addr   = addr;
    mm_if.wr_dat = data;
    mm_if.wr     = 1;
    @(negedge clk);
    mm_if.wr = 0;
  endtask

  task automatic read_expect(input string name, input logic [MM_A_BITS-1:0] addr,
                             input logic [63:0] req);
    logic [63:0] d;
    mm_read(addr, d);
    check_output(name, d, req);
  endtask

  initial begin
    logic [63:0] d;
    snk_if.val = 0; snk_if.sop = 0; snk_if.eop = 0; snk_if.err = 0;
    snk_if.ctl = 0; snk_if.dat = 0; snk_if.mod = 0;
    src_if.rdy = 1;
    mm_if.addr = 0; mm_if.wr = 0; mm_if.rd = 0; mm_if.wr_dat = 0;
    rand_rdy = 0;
    lat_check = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_src_val", src_if.val, 0);
    check_output("reset_snk_rdy", snk_if.rdy, 0);
    check_output("reset_rd_val", mm_if.rd_dat_val, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    #1;
    check_output("rdy_after_reset", snk_if.rdy, 1);
    read_expect("pkt_after_reset", 8'h00, 0);

    // 3-beat packet, always ready
    $display("[TB] three-beat packet");
    lat_check = 1;
    apply_stimulus(1, 0, 0, 0, 64'h1111_2222_3333_4444);
    apply_stimulus(0, 0, 0, 0, 64'h5555_6666_7777_8888);
    apply_stimulus(0, 1, 0, 5, 64'h9999_aaaa_bbbb_cccc);
    idle_cycles(3);
    lat_check = 0;
    read_expect("pkt_3beat", 8'h00, 1);
    read_expect("beat_3beat", 8'h01, 3);
    read_expect("byte_3beat", 8'h02, 21);
    read_expect("err_3beat", 8'h03, 0);

    // 100 single-beat packets under random backpressure
    $display("[TB] random backpressure");
    mm_write(8'h04, 1);
    delivered = 0;
    rand_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1, 1, 0, 3'($urandom), 64'(i));
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end
    idle_cycles(1);
    rand_rdy = 0;
    @(negedge clk);
    src_if.rdy = 1;
    repeat (5) @(negedge clk);
    check_output("delivered", delivered, 100);
    read_expect("beat_random", 8'h01, 100);
    read_expect("pkt_random", 8'h00, 100);
    read_expect("err_random", 8'h03, 0);

    // Framing errors
    $display("[TB] framing errors");
    mm_write(8'h04, 1);
    apply_stimulus(0, 0, 0, 0, 64'hdead_0001);
    idle_cycles(3);
    read_expect("err_no_sop", 8'h03, 1);
    apply_stimulus(1, 0, 0, 0, 64'hdead_0002);
    apply_stimulus(0, 1, 0, 0, 64'hdead_0003);
    idle_cycles(3);
    read_expect("err_mid_sop", 8'h03, 2);
    read_expect("pkt_framing", 8'h00, 1);

    // Upstream error with full last beat
    mm_write(8'h04, 1);
    apply_stimulus(1, 1, 1, 0, 64'hbeef);
    idle_cycles(3);
    read_expect("err_upstream", 8'h03, 1);
    read_expect("byte_mod0", 8'h02, 8);

    // Register port behaviour
    $display("[TB] register port");
    mm_write(8'h04, 1);
    apply_stimulus(1, 0, 0, 0, 64'h10);
    apply_stimulus(0, 0, 0, 0, 64'h11);
    apply_stimulus(0, 0, 0, 0, 64'h12);
    apply_stimulus(0, 1, 0, 2, 64'h13);
    idle_cycles(3);
    read_expect("beat_four", 8'h01, 4);
    @(negedge clk);
    src_if.rdy = 0;
    apply_stimulus(1, 1, 0, 0, 64'h20);
    idle_cycles(2);
    @(negedge clk);
    src_if.rdy   = 1;
    mm_if.addr   = 8'h04;
    mm_if.wr_dat = 1;
    mm_if.wr     = 1;
    @(negedge clk);
    mm_if.wr = 0;
    repeat (2) @(negedge clk);
    read_expect("pkt_cleared", 8'h00, 0);
    read_expect("beat_cleared", 8'h01, 0);
    read_expect("byte_cleared", 8'h02, 0);
    read_expect("err_cleared", 8'h03, 0);
    read_expect("unmapped", 8'h7f, 0);
    apply_stimulus(1, 1, 0, 0, 64'h30);
    idle_cycles(3);
    mm_write(8'h01, 64'hff);
    read_expect("beat_ro", 8'h01, 1);
    @(negedge clk);
    mm_if.addr   = 8'h04;
    mm_if.wr_dat = 1;
    mm_if.wr     = 1;
    mm_if.rd     = 1;
    @(negedge clk);
    mm_if.wr = 0;
    mm_if.rd = 0;
    #1;
    check_output("ctrl_rdwr_val", mm_if.rd_dat_val, 1);
    check_output("ctrl_rdwr_dat", mm_if.rd_dat, 0);
    read_expect("beat_after_rdwr", 8'h01, 0);

    // Reset with two beats buffered
    $display("[TB] reset mid-packet");
    apply_stimulus(1, 1, 0, 0, 64'h40);
    idle_cycles(3);
    @(negedge clk);
    src_if.rdy = 0;
    apply_stimulus(1, 0, 0, 0, 64'h41);
    apply_stimulus(0, 0, 0, 0, 64'h42);
    idle_cycles(1);
    #1;
    check_output("full_rdy_low", snk_if.rdy, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_output("rst_src_val", src_if.val, 0);
    check_output("rst_snk_rdy", snk_if.rdy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    src_if.rdy = 1;
    repeat (2) @(negedge clk);
    #1;
    check_output("rdy_after_rst2", snk_if.rdy, 1);
    read_expect("beat_after_rst2", 8'h01, 0);
    read_expect("pkt_after_rst2", 8'h00, 0);
    apply_stimulus(1, 1, 0, 3, 64'h50);
    idle_cycles(3);
    read_expect("pkt_clean", 8'h00, 1);
    read_expect("err_clean", 8'h03, 0);
    read_expect("byte_clean", 8'h02, 3);
    check_output("scoreboard_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
